// File: rtl/mem_ctrl.sv
// Byte-wide memory responder: on-chip RAM with one-cycle read latency,
// plus a small I/O window fronting 8-deep serial TX/RX byte FIFOs.

module mem_ctrl_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       pop_i,
    output logic [7:0] head_o,
    output logic       full_o,
    output logic       nempty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o   = (cnt_q == CW'(DEPTH));
    assign nempty_o = (cnt_q != '0);
    // Fullness is judged before this cycle's pop, so a full FIFO drops a push.
    assign do_push  = push_i && !full_o;
    assign do_pop   = pop_i && nempty_o;
    assign head_o   = nempty_o ? mem_q[rptr_q] : 8'h00;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q + CW'(do_push) - CW'(do_pop);
        if (do_push) wptr_d = wptr_q + PW'(1);
        if (do_pop)  rptr_d = rptr_q + PW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end
endmodule

module mem_ctrl #(
    parameter int ADDR_W     = 17,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mema_i,
    input  logic [7:0]  memd_i,
    input  logic        memwe_i,
    output logic [7:0]  memd_o,
    output logic        rdy_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i
);
    localparam logic [31:0] A_DATA = 32'h0003_0000;
    localparam logic [31:0] A_STAT = 32'h0003_0004;
    localparam logic [31:0] A_POP  = 32'h0003_0008;

    logic [7:0]        ram [2**ADDR_W];
    logic [ADDR_W-1:0] idx;
    logic              io;
    logic              sel_data, sel_stat, sel_pop;
    logic              tx_full;
    logic [7:0]        rx_head;
    logic              rx_full, rx_nempty;
    logic              rx_ovf_q, rx_ovf_d;
    logic [7:0]        memd_q, memd_d;
    logic [7:0]        io_rd;

    assign io       = (mema_i[17:16] == 2'b11);
    assign idx      = mema_i[ADDR_W-1:0];
    assign sel_data = (mema_i == A_DATA);
    assign sel_stat = (mema_i == A_STAT);
    assign sel_pop  = (mema_i == A_POP);

    // Only a TX push into a full FIFO may stall the pipeline.
    assign rdy_o  = !(memwe_i && sel_data && tx_full);
    assign memd_o = memd_q;

    mem_ctrl_fifo #(.DEPTH(FIFO_DEPTH)) u_tx (
        .clk      (clk),
        .rst      (rst),
        .push_i   (memwe_i && sel_data),
        .data_i   (memd_i),
        .pop_i    (tx_ready_i),
        .head_o   (tx_data_o),
        .full_o   (tx_full),
        .nempty_o (tx_valid_o)
    );

    mem_ctrl_fifo #(.DEPTH(FIFO_DEPTH)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .push_i   (rx_valid_i),
        .data_i   (rx_data_i),
        .pop_i    (memwe_i && sel_pop && rdy_o),
        .head_o   (rx_head),
        .full_o   (rx_full),
        .nempty_o (rx_nempty)
    );

    always_comb begin
        io_rd = 8'h00;
        if (sel_data)      io_rd = rx_head;
        else if (sel_stat) io_rd = {5'b0, rx_ovf_q, tx_full, rx_nempty};
    end

    always_comb begin
        rx_ovf_d = rx_ovf_q;
        if (memwe_i && sel_stat && rdy_o) rx_ovf_d = 1'b0;
        if (rx_valid_i && rx_full)        rx_ovf_d = 1'b1;
    end

    // Write cycles leave the read register untouched.
    always_comb begin
        memd_d = memd_q;
        if (!memwe_i && rdy_o) memd_d = io ? io_rd : ram[idx];
    end

    always_ff @(posedge clk) begin
        if (memwe_i && !io && rdy_o) ram[idx] <= memd_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memd_q   <= 8'h00;
            rx_ovf_q <= 1'b0;
        end else begin
            memd_q   <= memd_d;
            rx_ovf_q <= rx_ovf_d;
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: queue/array reference model checked every
// cycle, plus literal expectations at the interesting points.

module tb_mem_ctrl;
    localparam logic [31:0] A_DATA = 32'h0003_0000;
    localparam logic [31:0] A_STAT = 32'h0003_0004;
    localparam logic [31:0] A_POP  = 32'h0003_0008;
    localparam int          DEPTH  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] mema = A_STAT;
    logic [7:0]  memd = 8'h00;
    logic        memwe = 1'b0;
    logic [7:0]  memd_o;
    logic        rdy_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;

    int vecs = 0;
    int errs = 0;

    logic [7:0] txq [$];
    logic [7:0] rxq [$];
    logic [7:0] ram_m [int];
    logic [7:0] memd_m = 8'h00;
    bit         memd_known = 1'b1;
    bit         ovf_m = 1'b0;

    mem_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .mema_i     (mema),
        .memd_i     (memd),
        .memwe_i    (memwe),
        .memd_o     (memd_o),
        .rdy_o      (rdy_o),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin : model
        bit         txf, rxf, rdy_m;
        logic [7:0] st, hd;
        int         idx;
        if (rst) begin
            txq.delete();
            rxq.delete();
            memd_m     = 8'h00;
            memd_known = 1'b1;
            ovf_m      = 1'b0;
        end else begin
            txf   = (txq.size() == DEPTH);
            rxf   = (rxq.size() == DEPTH);
            rdy_m = !(memwe && mema == A_DATA && txf);
            hd    = (rxq.size() > 0) ? rxq[0] : 8'h00;
            st    = {5'b0, ovf_m, txf, rxq.size() > 0};
            idx   = int'(mema[16:0]);
            if (!memwe) begin
                if (mema[17:16] == 2'b11) begin
                    memd_known = 1'b1;
                    memd_m = (mema == A_DATA) ? hd : (mema == A_STAT) ? st : 8'h00;
                end else if (ram_m.exists(idx)) begin
                    memd_known = 1'b1;
                    memd_m = ram_m[idx];
                end else begin
                    memd_known = 1'b0;
                end
            end else if (rdy_m && mema[17:16] != 2'b11) begin
                ram_m[idx] = memd;
            end
            if (txq.size() > 0 && tx_ready) void'(txq.pop_front());
            if (memwe && mema == A_DATA && !txf) txq.push_back(memd);
            if (memwe && mema == A_POP && rxq.size() > 0) void'(rxq.pop_front());
            if (rx_valid && !rxf) rxq.push_back(rx_data);
            ovf_m = (rx_valid && rxf) || (ovf_m && !(memwe && mema == A_STAT));
        end
    end

    always @(negedge clk) begin
        check("rdy_o", 32'(rdy_o),
              32'(!(memwe && mema == A_DATA && txq.size() == DEPTH)));
        check("tx_valid_o", 32'(tx_valid_o), 32'(txq.size() > 0));
        check("tx_data_o", 32'(tx_data_o),
              (txq.size() > 0) ? 32'(txq[0]) : 32'h0);
        if (memd_known) check("memd_o", 32'(memd_o), 32'(memd_m));
    end

    task automatic cyc(input logic [31:0] a, input logic w, input logic [7:0] d);
        mema  = a;
        memwe = w;
        memd  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic inject(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        check("rst memd_o", 32'(memd_o), 32'h00);
        check("rst rdy_o", 32'(rdy_o), 32'h1);
        check("rst tx_valid_o", 32'(tx_valid_o), 32'h0);
        check("rst tx_data_o", 32'(tx_data_o), 32'h00);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // RAM write/read, aliasing through ignored upper bits, top index
        cyc(32'h0000_0010, 1'b1, 8'hA5);
        cyc(32'h0001_FFFF, 1'b1, 8'h3C);
        cyc(32'h0000_0010, 1'b0, 8'h00);
        check("ram rd 0x10", 32'(memd_o), 32'hA5);
        cyc(32'h0001_FFFF, 1'b0, 8'h00);
        check("ram rd 0x1FFFF", 32'(memd_o), 32'h3C);
        cyc(32'h0002_0010, 1'b0, 8'h00);
        check("ram alias 0x20010", 32'(memd_o), 32'hA5);
        cyc(32'hFF02_0010, 1'b0, 8'h00);
        check("ram alias 0xFF020010", 32'(memd_o), 32'hA5);

        // Unmapped I/O addresses
        cyc(32'h0003_0001, 1'b1, 8'h77);
        check("byte 0x30001 no push", 32'(tx_valid_o), 32'h0);
        cyc(A_POP, 1'b0, 8'h00);
        check("rd 0x30008", 32'(memd_o), 32'h00);
        cyc(32'hFF03_0000, 1'b0, 8'h00);
        check("rd inexact io", 32'(memd_o), 32'h00);

        // TX basic push and drain
        cyc(A_DATA, 1'b1, 8'h41);
        cyc(A_DATA, 1'b1, 8'h42);
        cyc(A_STAT, 1'b0, 8'h00);
        check("tx head 41", 32'(tx_data_o), 32'h41);
        check("tx valid", 32'(tx_valid_o), 32'h1);
        tx_ready = 1'b1;
        cyc(A_STAT, 1'b0, 8'h00);
        check("tx head 42", 32'(tx_data_o), 32'h42);
        cyc(A_STAT, 1'b0, 8'h00);
        tx_ready = 1'b0;
        check("tx drained", 32'(tx_valid_o), 32'h0);

        // TX same-cycle push and pop
        cyc(A_DATA, 1'b1, 8'h11);
        tx_ready = 1'b1;
        cyc(A_DATA, 1'b1, 8'h22);
        tx_ready = 1'b0;
        check("tx push+pop head", 32'(tx_data_o), 32'h22);
        tx_ready = 1'b1;
        cyc(A_STAT, 1'b0, 8'h00);
        tx_ready = 1'b0;
        check("tx push+pop drained", 32'(tx_valid_o), 32'h0);

        // TX full stall
        for (int i = 0; i < 8; i++) cyc(A_DATA, 1'b1, 8'(8'h80 + i));
        cyc(A_STAT, 1'b0, 8'h00);
        check("status tx_full", 32'(memd_o), 32'h02);
        mema = A_DATA; memwe = 1'b1; memd = 8'h88;
        #1;
        check("stall rdy_o", 32'(rdy_o), 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("stall held rdy_o", 32'(rdy_o), 32'h0);
        check("stall memd_o holds", 32'(memd_o), 32'h02);
        tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        check("unstall rdy_o", 32'(rdy_o), 32'h1);
        @(posedge clk); #1;
        cyc(A_STAT, 1'b0, 8'h00);
        check("full again", 32'(memd_o), 32'h02);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("tx drain order", 32'(tx_data_o), 32'(8'h81 + i));
            cyc(A_STAT, 1'b0, 8'h00);
        end
        tx_ready = 1'b0;
        check("tx empty after drain", 32'(tx_valid_o), 32'h0);

        // RX basic
        inject(8'h55);
        inject(8'h66);
        cyc(A_DATA, 1'b0, 8'h00);
        check("rx head 55", 32'(memd_o), 32'h55);
        cyc(A_DATA, 1'b0, 8'h00);
        check("rx head 55 again", 32'(memd_o), 32'h55);
        cyc(A_STAT, 1'b0, 8'h00);
        check("rx status 01", 32'(memd_o), 32'h01);
        cyc(A_POP, 1'b1, 8'h00);
        cyc(A_DATA, 1'b0, 8'h00);
        check("rx head 66", 32'(memd_o), 32'h66);
        cyc(A_POP, 1'b1, 8'h00);
        cyc(A_STAT, 1'b0, 8'h00);
        check("rx status 00", 32'(memd_o), 32'h00);
        cyc(A_POP, 1'b1, 8'h00);
        cyc(A_DATA, 1'b0, 8'h00);
        check("rx empty head", 32'(memd_o), 32'h00);

        // RX overflow
        for (int i = 0; i < 9; i++) inject(8'(8'h10 + i));
        cyc(A_STAT, 1'b0, 8'h00);
        check("rx ovf status", 32'(memd_o), 32'h05);
        cyc(A_DATA, 1'b0, 8'h00);
        check("rx ovf head", 32'(memd_o), 32'h10);
        cyc(A_STAT, 1'b1, 8'hFF);
        cyc(A_STAT, 1'b0, 8'h00);
        check("rx ovf cleared", 32'(memd_o), 32'h01);
        rx_valid = 1'b1; rx_data = 8'h99;
        cyc(A_POP, 1'b1, 8'h00);
        rx_valid = 1'b0;
        cyc(A_STAT, 1'b0, 8'h00);
        check("full pop+push drops", 32'(memd_o), 32'h05);
        cyc(A_DATA, 1'b0, 8'h00);
        check("head after pop", 32'(memd_o), 32'h11);
        inject(8'h9A);
        rx_valid = 1'b1; rx_data = 8'h9B;
        cyc(A_STAT, 1'b1, 8'h00);
        rx_valid = 1'b0;
        cyc(A_STAT, 1'b0, 8'h00);
        check("ovf set wins", 32'(memd_o), 32'h05);
        cyc(A_STAT, 1'b1, 8'h00);
        cyc(A_STAT, 1'b0, 8'h00);
        check("ovf clear", 32'(memd_o), 32'h01);
        for (int i = 0; i < 7; i++) cyc(A_POP, 1'b1, 8'h00);
        cyc(A_DATA, 1'b0, 8'h00);
        check("rx last head", 32'(memd_o), 32'h9A);
        cyc(A_POP, 1'b1, 8'h00);
        cyc(A_STAT, 1'b0, 8'h00);
        check("rx final status", 32'(memd_o), 32'h00);

        // Reset during TX-full stall
        for (int i = 0; i < 8; i++) cyc(A_DATA, 1'b1, 8'(8'hC0 + i));
        mema = A_DATA; memwe = 1'b1; memd = 8'hC8;
        #1;
        check("pre-rst stall", 32'(rdy_o), 32'h0);
        #1 rst = 1'b1;
        #1;
        check("rst stall rdy_o", 32'(rdy_o), 32'h1);
        check("rst stall tx_valid", 32'(tx_valid_o), 32'h0);
        check("rst stall memd_o", 32'(memd_o), 32'h00);
        mema = A_STAT; memwe = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(32'h0000_0010, 1'b0, 8'h00);
        check("ram survives rst", 32'(memd_o), 32'hA5);
        cyc(A_STAT, 1'b0, 8'h00);
        check("status after rst", 32'(memd_o), 32'h00);

        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
